// File: rtl/y86_trace_pkg.sv
// y86_trace_pkg: shared trace-capture states and the default-width entry record
package y86_trace_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;
   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   localparam int NREG_DEF   = 8;
   localparam int IDX_W_DEF  = $clog2(NREG_DEF);
   typedef struct packed {
      logic [ADDR_W_DEF-1:0] pc;
      logic                  wr_en;
      logic [IDX_W_DEF-1:0]  wr_idx;
      logic [DATA_W_DEF-1:0] wr_data;
   } entry_t;
   localparam int ENTRY_W_DEF = $bits(entry_t);
endpackage

// File: rtl/y86_trace_ram.sv
// y86_trace_ram: simple dual-port entry store, synchronous write, registered read
module y86_trace_ram #(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [W-1:0]             i_wdata,
   input  logic                     i_re,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [W-1:0]             o_rdata
);
   logic [W-1:0] r_mem [DEPTH];
   always_ff @(posedge clk)
      if (i_we) r_mem[i_waddr] <= i_wdata;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) o_rdata <= '0;
      else if (i_re) o_rdata <= r_mem[i_raddr];
endmodule

// File: rtl/y86_trace_buffer.sv
// y86_trace_buffer: circular retire-trace capture with PC trigger, post window and oldest-first drain
module y86_trace_buffer
   import y86_trace_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int NREG      = 8,
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_retire_valid,
   input  logic [ADDR_W-1:0]          i_retire_pc,
   input  logic                       i_retire_wr_en,
   input  logic [$clog2(NREG)-1:0]    i_retire_wr_idx,
   input  logic [DATA_W-1:0]          i_retire_wr_data,
   input  logic                       i_arm,
   input  logic                       i_clr,
   input  logic                       i_trig_en,
   input  logic [ADDR_W-1:0]          i_trig_pc,
   input  logic                       i_rd_req,
   output logic                       o_rd_valid,
   output logic [ADDR_W-1:0]          o_rd_pc,
   output logic                       o_rd_wr_en,
   output logic [$clog2(NREG)-1:0]    o_rd_wr_idx,
   output logic [DATA_W-1:0]          o_rd_wr_data,
   output logic                       o_rd_last,
   output logic [1:0]                 o_state,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_wrapped
);
   localparam int IDX_W = $clog2(NREG);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = ADDR_W + 1 + IDX_W + DATA_W;
   state_t           r_state, w_state_nx;
   logic [PTR_W-1:0] r_wr_ptr, w_wr_ptr_nx, r_rd_ptr, w_rd_ptr_nx, r_post, w_post_nx;
   logic [CNT_W-1:0] r_count, w_count_nx;
   logic             r_wrapped, w_wrapped_nx, r_rd_valid, r_rd_last;
   logic             w_full, w_cap, w_trig, w_rd;
   logic [ENT_W-1:0] w_rdata;
   assign w_full = r_count == CNT_W'(DEPTH);
   assign w_cap  = !i_clr && i_retire_valid && (r_state == ARMED || r_state == POST);
   assign w_trig = w_cap && r_state == ARMED && i_trig_en && i_retire_pc == i_trig_pc;
   assign w_rd   = !i_clr && r_state == DONE && i_rd_req;
   always_comb begin
      w_state_nx   = r_state;
      w_wr_ptr_nx  = r_wr_ptr;
      w_rd_ptr_nx  = r_rd_ptr;
      w_post_nx    = r_post;
      w_count_nx   = r_count;
      w_wrapped_nx = r_wrapped;
      if (i_clr) begin
         w_state_nx   = IDLE;
         w_count_nx   = '0;
         w_wrapped_nx = 1'b0;
      end else if (r_state == IDLE && i_arm) begin
         w_state_nx   = ARMED;
         w_count_nx   = '0;
         w_wrapped_nx = 1'b0;
         w_wr_ptr_nx  = '0;
      end else if (w_cap) begin
         w_wr_ptr_nx  = r_wr_ptr + PTR_W'(1);
         w_count_nx   = w_full ? r_count : r_count + CNT_W'(1);
         w_wrapped_nx = r_wrapped | w_full;
         if (w_trig) begin
            w_post_nx  = PTR_W'(POST_TRIG);
            w_state_nx = POST_TRIG == 0 ? DONE : POST;
         end else if (r_state == POST) begin
            w_post_nx  = r_post - PTR_W'(1);
            w_state_nx = r_post == PTR_W'(1) ? DONE : POST;
         end
         // tracked on every capture so it already holds the oldest slot when DONE is entered
         w_rd_ptr_nx = w_wrapped_nx ? w_wr_ptr_nx : '0;
      end else if (w_rd) begin
         w_rd_ptr_nx = r_rd_ptr + PTR_W'(1);
         w_count_nx  = r_count - CNT_W'(1);
         w_state_nx  = r_count == CNT_W'(1) ? IDLE : DONE;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state    <= IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_post     <= '0;
         r_count    <= '0;
         r_wrapped  <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_last  <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_wr_ptr   <= w_wr_ptr_nx;
         r_rd_ptr   <= w_rd_ptr_nx;
         r_post     <= w_post_nx;
         r_count    <= w_count_nx;
         r_wrapped  <= w_wrapped_nx;
         r_rd_valid <= w_rd;
         r_rd_last  <= w_rd && r_count == CNT_W'(1);
      end
   y86_trace_ram #(.W(ENT_W), .DEPTH(DEPTH)) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_cap),
      .i_waddr (r_wr_ptr),
      .i_wdata ({i_retire_pc, i_retire_wr_en, i_retire_wr_idx, i_retire_wr_data}),
      .i_re    (w_rd),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );
   assign {o_rd_pc, o_rd_wr_en, o_rd_wr_idx, o_rd_wr_data} = w_rdata;
   assign o_rd_valid = r_rd_valid;
   assign o_rd_last  = r_rd_last;
   assign o_state    = r_state;
   assign o_count    = r_count;
   assign o_wrapped  = r_wrapped;
endmodule

// File: tb/tb_y86_trace_buffer.sv
// tb_y86_trace_buffer: queue-model scoreboard bench for the trace buffer
module tb_y86_trace_buffer;
   localparam int DEPTH = 8;
   localparam int PT    = 3;
   typedef struct packed {logic [31:0] pc; logic we; logic [2:0] idx; logic [31:0] data;} ent_t;
   typedef struct packed {ent_t e; logic last;} rd_t;
   logic clk = 1'b0, rst_n = 1'b0;
   logic retire_valid = 1'b0, retire_wr_en = 1'b0, arm = 1'b0, clr = 1'b0, trig_en = 1'b0, rd_req = 1'b0;
   logic [31:0] retire_pc = '0, retire_wr_data = '0, trig_pc = '0;
   logic [2:0] retire_wr_idx = '0;
   logic a_rd_valid, a_rd_wr_en, a_rd_last, a_wrapped, b_rd_valid, b_rd_wr_en, b_rd_last, b_wrapped;
   logic [31:0] a_rd_pc, a_rd_wr_data, b_rd_pc, b_rd_wr_data;
   logic [2:0] a_rd_wr_idx, b_rd_wr_idx;
   logic [1:0] a_state, b_state;
   logic [3:0] a_count, b_count;
   int passed = 0, total = 0;
   ent_t m_q[$];
   rd_t exp_q[$];
   int m_state = 0, m_post = 0;
   bit m_wrapped = 0;
   always #5 clk = ~clk;
   y86_trace_buffer #(.ADDR_W(32), .DATA_W(32), .NREG(8), .DEPTH(DEPTH), .POST_TRIG(PT)) u_dut (
      .clk(clk), .rst_n(rst_n), .i_retire_valid(retire_valid), .i_retire_pc(retire_pc),
      .i_retire_wr_en(retire_wr_en), .i_retire_wr_idx(retire_wr_idx), .i_retire_wr_data(retire_wr_data),
      .i_arm(arm), .i_clr(clr), .i_trig_en(trig_en), .i_trig_pc(trig_pc), .i_rd_req(rd_req),
      .o_rd_valid(a_rd_valid), .o_rd_pc(a_rd_pc), .o_rd_wr_en(a_rd_wr_en), .o_rd_wr_idx(a_rd_wr_idx),
      .o_rd_wr_data(a_rd_wr_data), .o_rd_last(a_rd_last), .o_state(a_state), .o_count(a_count), .o_wrapped(a_wrapped));
   y86_trace_buffer #(.ADDR_W(32), .DATA_W(32), .NREG(8), .DEPTH(DEPTH), .POST_TRIG(0)) u_edge (
      .clk(clk), .rst_n(rst_n), .i_retire_valid(retire_valid), .i_retire_pc(retire_pc),
      .i_retire_wr_en(retire_wr_en), .i_retire_wr_idx(retire_wr_idx), .i_retire_wr_data(retire_wr_data),
      .i_arm(arm), .i_clr(clr), .i_trig_en(trig_en), .i_trig_pc(trig_pc), .i_rd_req(rd_req),
      .o_rd_valid(b_rd_valid), .o_rd_pc(b_rd_pc), .o_rd_wr_en(b_rd_wr_en), .o_rd_wr_idx(b_rd_wr_idx),
      .o_rd_wr_data(b_rd_wr_data), .o_rd_last(b_rd_last), .o_state(b_state), .o_count(b_count), .o_wrapped(b_wrapped));
   task automatic check(string name, longint act, longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   // reference: the buffer is a bounded queue of the most recent retirements
   function automatic void model_edge();
      ent_t e;
      if (clr) begin
         m_state = 0; m_q.delete(); m_wrapped = 0;
      end else if (m_state == 0) begin
         if (arm) begin m_state = 1; m_q.delete(); m_wrapped = 0; end
      end else if (m_state == 3) begin
         if (rd_req) begin
            e = m_q.pop_front();
            exp_q.push_back({e, m_q.size() == 0});
            if (m_q.size() == 0) m_state = 0;
         end
      end else if (retire_valid) begin
         m_q.push_back({retire_pc, retire_wr_en, retire_wr_idx, retire_wr_data});
         if (m_q.size() > DEPTH) begin m_q.delete(0); m_wrapped = 1; end
         if (m_state == 1 && trig_en && retire_pc == trig_pc) begin
            m_post = PT; m_state = PT == 0 ? 3 : 2;
         end else if (m_state == 2) begin
            m_post--;
            if (m_post == 0) m_state = 3;
         end
      end
   endfunction
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("state", a_state, m_state);
      check("count", a_count, m_q.size());
      check("wrapped", a_wrapped, m_wrapped);
      retire_valid = 0; arm = 0; clr = 0; rd_req = 0;
   endtask
   task automatic retire(input logic [31:0] pc, input logic we, input logic [2:0] idx, input logic [31:0] data);
      retire_valid = 1; retire_pc = pc; retire_wr_en = we; retire_wr_idx = idx; retire_wr_data = data;
      tick();
   endtask
   task automatic retire_rand(input logic [31:0] pc);
      retire(pc, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
   endtask
   task automatic drain();
      for (int k = 0; k < DEPTH + 2 && m_state == 3; k++) begin rd_req = 1; tick(); end
      tick();
   endtask
   always @(negedge clk) begin
      rd_t x;
      if (rst_n && (a_rd_valid || exp_q.size() != 0)) begin
         total++;
         if (exp_q.size() == 0)
            $display("FAIL rd_unexpected: got rd_valid=1 pc=%0h expected rd_valid=0", a_rd_pc);
         else begin
            x = exp_q.pop_front();
            if (a_rd_valid && {a_rd_pc, a_rd_wr_en, a_rd_wr_idx, a_rd_wr_data} == x.e && a_rd_last == x.last) passed++;
            else $display("FAIL rd_entry: got v=%0b pc=%0h we=%0b idx=%0d d=%0h last=%0b expected pc=%0h we=%0b idx=%0d d=%0h last=%0b",
                          a_rd_valid, a_rd_pc, a_rd_wr_en, a_rd_wr_idx, a_rd_wr_data, a_rd_last,
                          x.e.pc, x.e.we, x.e.idx, x.e.data, x.last);
         end
      end
   end
   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", a_state, 0);
      check("rst_count", a_count, 0);
      check("rst_wrapped", a_wrapped, 0);
      check("rst_rd_valid", a_rd_valid, 0);
      check("rst_rd_last", a_rd_last, 0);
      check("rst_rd_pc", a_rd_pc, 0);
      rst_n = 1;
      trig_en = 1; trig_pc = 32'h08; arm = 1; tick();
      for (int i = 0; i < 6; i++) retire_rand(32'(4 * i));
      check("basic_done", a_state, 3);
      check("basic_count", a_count, 6);
      drain();
      trig_pc = 32'h40; arm = 1; tick();
      for (int i = 0; i < 20; i++) retire_rand(32'(4 * i));
      check("wrap_count", a_count, 8);
      check("wrap_flag", a_wrapped, 1);
      drain();
      trig_pc = 32'h200; arm = 1; tick();
      retire_rand(32'h100);
      retire(32'h200, 1, 3, 32'hDEADBEEF);
      for (int k = 0; k < 3; k++) begin
         tick(); tick();
         check("bubble_not_done", a_state, 2);
         retire(32'h300 + 32'(4 * k), 1, 3, 32'hDEADBEEF);
      end
      check("bubble_done", a_state, 3);
      drain();
      trig_pc = 32'h1030; arm = 1; tick();
      for (int i = 0; i < 13; i++) retire_rand(32'h1000 + 32'(4 * i));
      check("abort_pre_wrapped", a_wrapped, 1);
      clr = 1; tick();
      check("abort_idle", a_state, 0);
      arm = 1; tick();
      check("rearm_wrapped", a_wrapped, 0);
      retire_rand(32'h2000);
      clr = 1; arm = 1; tick();
      check("clr_arm_idle", a_state, 0);
      trig_pc = 32'h500; arm = 1; tick();
      rd_req = 1; tick();
      check("edge_armed_no_rd", b_rd_valid, 0);
      retire_rand(32'h500);
      check("edge_done", b_state, 3);
      check("edge_count", b_count, 1);
      rd_req = 1; tick();
      check("edge_rd_valid", b_rd_valid, 1);
      check("edge_rd_last", b_rd_last, 1);
      check("edge_rd_pc", b_rd_pc, 32'h500);
      check("edge_idle", b_state, 0);
      clr = 1; tick();
      for (int n = 0; n < 3000; n++) begin
         trig_pc = 32'(4 * $urandom_range(0, 15));
         retire_valid = 1'($urandom_range(0, 1));
         retire_pc = 32'(4 * $urandom_range(0, 15));
         retire_wr_en = 1'($urandom_range(0, 1));
         retire_wr_idx = 3'($urandom_range(0, 7));
         retire_wr_data = $urandom;
         arm = $urandom_range(0, 3) == 0;
         rd_req = 1'($urandom_range(0, 1));
         clr = $urandom_range(0, 99) == 0;
         tick();
      end
      tick(); tick();
      check("sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
